// File: rtl/alu_pkg.sv
// Opcode map, opcode classification helpers and issuer FSM encoding shared by the
// ALU datapath blocks.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LSH = 4'd10;
    localparam logic [3:0] OP_RSH = 4'd11;
    localparam logic [3:0] OP_POW = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // NOP is reserved as illegal so a zeroed bus never looks like real work.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_POW);
    endfunction

    function automatic logic is_slow_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_POW);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the ALU, waits its opcode-dependent latency and
// returns the captured result; illegal opcodes and divide-by-zero are trapped here.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int BIT_LEN  = 8,
    parameter int LAT_FAST = 1,
    parameter int LAT_SLOW = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [3:0]         CMD_OP,
    input  logic [BIT_LEN-1:0] CMD_A,
    input  logic [BIT_LEN-1:0] CMD_B,
    output logic               ALU_EN,
    output logic [3:0]         ALU_OP,
    output logic [BIT_LEN-1:0] ALU_A,
    output logic [BIT_LEN-1:0] ALU_B,
    input  logic [BIT_LEN-1:0] ALU_DEST,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [BIT_LEN-1:0] RES_DATA,
    output logic               RES_ERR,
    output logic [7:0]         ERR_CNT
);

    localparam int CNT_W = $clog2(LAT_SLOW + 1);
    localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST);
    localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               alu_en_q, alu_en_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [BIT_LEN-1:0] alu_a_q, alu_a_d;
    logic [BIT_LEN-1:0] alu_b_q, alu_b_d;
    logic [BIT_LEN-1:0] res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [7:0]         err_cnt_inc;

    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_en_d   = alu_en_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    if (!is_legal_op(CMD_OP)) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        err_cnt_d  = err_cnt_inc;
                        state_d    = ST_RESP;
                    end else if ((CMD_OP == OP_DIV) && (CMD_B == '0)) begin
                        res_data_d = '1;
                        res_err_d  = 1'b1;
                        err_cnt_d  = err_cnt_inc;
                        state_d    = ST_RESP;
                    end else begin
                        alu_en_d = 1'b1;
                        alu_op_d = CMD_OP;
                        alu_a_d  = CMD_A;
                        alu_b_d  = CMD_B;
                        cnt_d    = is_slow_op(CMD_OP) ? CNT_SLOW : CNT_FAST;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Operands stay on the bus until the result is sampled.
                if (cnt_q == CNT_ONE) begin
                    res_data_d = ALU_DEST;
                    res_err_d  = 1'b0;
                    alu_en_d   = 1'b0;
                    alu_op_d   = '0;
                    alu_a_d    = '0;
                    alu_b_d    = '0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RES_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_en_q   <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_en_q   <= alu_en_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Ready is masked by reset so nothing is offered while the block is held.
    assign CMD_READY = (state_q == ST_IDLE) && !RST;
    assign RES_VALID = (state_q == ST_RESP);
    assign ALU_EN    = alu_en_q;
    assign ALU_OP    = alu_op_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign RES_DATA  = res_data_q;
    assign RES_ERR   = res_err_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small combinational ALU model on ALU_DEST.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic       alu_en;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_dest;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.BIT_LEN(8), .LAT_FAST(1), .LAT_SLOW(4)) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
        .CMD_A(cmd_a), .CMD_B(cmd_b),
        .ALU_EN(alu_en), .ALU_OP(alu_op), .ALU_A(alu_a), .ALU_B(alu_b),
        .ALU_DEST(alu_dest),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
        .RES_ERR(res_err), .ERR_CNT(err_cnt)
    );

    always_comb begin
        alu_dest = 8'h00;
        case (alu_op)
            4'd1: alu_dest = alu_a + alu_b;
            4'd2: alu_dest = alu_a - alu_b;
            4'd3: alu_dest = alu_a * alu_b;
            default: alu_dest = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a command for exactly one edge; the caller has checked readiness.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic hard_reset;
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state while held
        #2;
        check("rst_ready", cmd_ready, 0);
        check("rst_outs", {alu_en, alu_op, alu_a, alu_b, res_valid, res_data, res_err, err_cnt}, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", cmd_ready, 1);

        // Reset pulsed during WAIT discards the command
        tick();
        issue(4'd1, 8'd5, 8'd3);
        check("mid_wait_en", alu_en, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outs", {alu_en, alu_op, alu_a, alu_b, res_valid, res_data, res_err, err_cnt}, 0);
        check("mid_rst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", cmd_ready, 1);
        tick(); tick();
        check("mid_no_resp", res_valid, 0);

        // ADD F0+20 -> 10, fast latency
        issue(4'd1, 8'hF0, 8'h20);
        check("add_en", {alu_en, alu_op, alu_a, alu_b}, {1'b1, 4'd1, 8'hF0, 8'h20});
        check("add_notyet", res_valid, 0);
        check("add_busy", cmd_ready, 0);
        tick();
        check("add_valid", res_valid, 1);
        check("add_res", {res_data, res_err}, {8'h10, 1'b0});
        check("add_alu_idle", {alu_en, alu_op, alu_a, alu_b}, 0);
        check("add_ready_low", cmd_ready, 0);
        tick();
        check("add_drop", {res_valid, cmd_ready}, 2'b01);
        check("add_hold", {res_data, res_err}, {8'h10, 1'b0});

        // MUL 3*4 -> 12, slow latency with stable operands
        issue(4'd3, 8'd3, 8'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul_bus%0d", i), {alu_en, alu_op, alu_a, alu_b, res_valid},
                  {1'b1, 4'd3, 8'd3, 8'd4, 1'b0});
            if (i < 3) tick();
        end
        tick();
        check("mul_valid", res_valid, 1);
        check("mul_res", {res_data, res_err, alu_en}, {8'd12, 1'b0, 1'b0});
        tick();

        // DIV by zero is trapped without touching the ALU
        issue(4'd4, 8'd9, 8'd0);
        check("div0_valid", res_valid, 1);
        check("div0_res", {res_data, res_err, err_cnt, alu_en}, {8'hFF, 1'b1, 8'd1, 1'b0});
        tick();

        // Illegal opcodes from a fresh counter
        hard_reset();
        issue(4'd14, 8'd1, 8'd2);
        check("op14_res", {res_valid, res_data, res_err, err_cnt, alu_en}, {1'b1, 8'd0, 1'b1, 8'd1, 1'b0});
        tick();
        issue(4'd0, 8'd1, 8'd2);
        check("op0_res", {res_valid, res_data, res_err, err_cnt, alu_en}, {1'b1, 8'd0, 1'b1, 8'd2, 1'b0});
        tick();
        for (int i = 0; i < 260; i++) begin
            issue(4'd15, 8'd0, 8'd0);
            tick();
        end
        check("err_sat", err_cnt, 8'd255);

        // Backpressure: SUB 7-2 held while a new command waits
        res_ready = 1'b0;
        issue(4'd2, 8'd7, 8'd2);
        tick();
        cmd_op    = 4'd1;
        cmd_a     = 8'd1;
        cmd_b     = 8'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_hold%0d", i), {res_valid, res_data, res_err, cmd_ready, alu_en},
                  {1'b1, 8'd5, 1'b0, 1'b0, 1'b0});
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("bp_release", {res_valid, cmd_ready, alu_en}, 3'b010);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_acc", {alu_en, alu_op, alu_a, alu_b}, {1'b1, 4'd1, 8'd1, 8'd1});
        tick();
        check("bp_next_res", {res_valid, res_data}, {1'b1, 8'd2});
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Issue side of the video-card ALU datapath.
- Accepts one arithmetic/logic command at a time over a valid/ready interface and drives the ALU operand, opcode and enable lines.
- Waits the opcode-dependent ALU latency, captures the ALU result and returns it over a valid/ready response interface.
- Traps illegal opcodes and divide-by-zero before they reach the ALU.

Parameters:
- BIT_LEN, 8, width of operands and result.
- LAT_FAST, 1, ALU latency in clocks for ADD/SUB/AND/OR/XOR/NOR/NOT/LSH/RSH; must be >= 1.
- LAT_SLOW, 4, ALU latency in clocks for MUL/DIV/POW; must be >= LAT_FAST.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  issuer can accept a command
- CMD_OP  in  4  opcode
- CMD_A  in  BIT_LEN  operand A
- CMD_B  in  BIT_LEN  operand B
- ALU_EN  out  1  ALU operation enable
- ALU_OP  out  4  opcode to ALU
- ALU_A  out  BIT_LEN  ALU SOURCE_A
- ALU_B  out  BIT_LEN  ALU SOURCE_B
- ALU_DEST  in  BIT_LEN  ALU result
- RES_VALID  out  1  result present
- RES_READY  in  1  consumer accepts result
- RES_DATA  out  BIT_LEN  result value
- RES_ERR  out  1  command was trapped
- ERR_CNT  out  8  saturating count of trapped commands

Behaviour:
- Opcodes: NOP=0, ADD=1, SUB=2, MUL=3, DIV=4, AND=5, OR=6, XOR=7, NOR=8, NOT=9, LSH=10, RSH=11, POW=12. Codes 0 and 13-15 are illegal.
- Reset (async, any state): state=IDLE. CMD_READY=0 while RST is high, 1 in the first cycle after release. ALU_EN=0, ALU_OP=0, ALU_A=0, ALU_B=0, RES_VALID=0, RES_DATA=0, RES_ERR=0, ERR_CNT=0. An in-flight command is discarded and no response is produced.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - CMD_READY=1; accept on CMD_VALID&&CMD_READY at a rising edge.
  - Legal opcode, and not (DIV with CMD_B==0): register CMD_OP/A/B onto ALU_OP/A/B, set ALU_EN=1, load the latency counter (LAT_SLOW for MUL/DIV/POW, else LAT_FAST), go to WAIT.
  - Illegal opcode: RES_DATA=0, RES_ERR=1, ERR_CNT+1 (saturates at 255), go to RESP. ALU_EN stays 0.
  - DIV with B=0: RES_DATA=all ones, RES_ERR=1, ERR_CNT+1, go to RESP. ALU_EN stays 0.
- WAIT:
  - CMD_READY=0. ALU_OP/A/B are held stable and ALU_EN=1 throughout.
  - Counter decrements each edge. On the edge where the counter==1: RES_DATA<=ALU_DEST, RES_ERR<=0, ALU_EN<=0, ALU_OP/A/B<=0, go to RESP.
- RESP:
  - RES_VALID=1. RES_DATA and RES_ERR are held stable until RES_READY is sampled high, then go to IDLE.
  - RES_VALID drops on that edge. RES_DATA/RES_ERR hold their last value.
- Latency from the accepting edge to RES_VALID high:
  - Legal op: LAT+1 edges (fast: 2, slow: 5 at defaults).
  - Trapped op: 1 edge.
- Throughput: one outstanding command. CMD_READY never rises in the same cycle RES_VALID is high, so the minimum command-to-command interval is LAT+2 cycles.
- RES_READY held high permanently: the response is consumed in its first RESP cycle.
- CMD_VALID while not ready: ignored, no state change; the source must hold its command.
- Counter width: clog2(LAT_SLOW+1). No arithmetic is performed here; all result width handling belongs to the ALU.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (NOP..POW);
  - an is_legal_op function;
  - an is_slow_op function (MUL/DIV/POW);
  - FSM state encoding.
- The ALU and any future opcode decoder import the same package.
- No sub-module; the FSM, counter and registers fit in one module.

Test Plan:
- Reset mid-WAIT: ADD 5,3 accepted, then RST pulsed at cycle 1 -> all outputs 0 immediately, no RES_VALID, CMD_READY=1 after release.
- ADD A=8'hF0, B=8'h20, ALU model returns 8'h10 -> ALU_EN high for 1 cycle, RES_VALID 2 edges after accept, RES_DATA=8'h10, RES_ERR=0.
- MUL A=3, B=4, ALU model returns 12 -> ALU_OP=3 stable for 4 cycles, RES_VALID 5 edges after accept, RES_DATA=12.
- DIV A=9, B=0 -> ALU_EN never asserts, RES_VALID after 1 edge, RES_DATA=8'hFF, RES_ERR=1, ERR_CNT=1.
- Opcode 14, then opcode 0 -> both RES_ERR=1, RES_DATA=0, ERR_CNT=2. With ERR_CNT preloaded via 260 illegal commands -> ERR_CNT=255.
- Backpressure: SUB 7,2 with RES_READY low for 6 cycles -> RES_VALID/RES_DATA=5 stable, CMD_READY=0 throughout, a new command is accepted only after the RES_READY edge.
